// File: rtl/bin_bank_read_seq.sv
// Purpose : walk NUM banks with a one-hot read strobe, capture the reduced read
//           word one cycle later into a small FIFO, present it downstream.
// Latency : first strobe the cycle after the start edge; valid_o 2 cycles after it.
// Backpr. : strobes stall while FIFO count + reads in flight would reach FIFO_DEPTH.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start_i/first_i/len_i start request, first bank, read count (sampled in IDLE only)
//   rd_o                  registered one-hot bank read strobe, 0 when not issuing
//   data_i                reducer output, valid the cycle after a strobe
//   data_o/valid_o/ready_i FIFO head word and valid/ready handshake
//   busy_o, done_o        not-idle flag, one-cycle end-of-sequence pulse
module bin_bank_read_seq #(
   parameter int NUM        = 8,
   parameter int WIDTH      = 5,
   parameter int IDX_W      = 3,
   parameter int CNT_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [IDX_W-1:0] first_i,
   input  logic [CNT_W-1:0] len_i,
   output logic [NUM-1:0]   rd_o,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             done_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] ptr;          // bank of the next strobe to load
   logic [CNT_W-1:0] remain;       // reads whose strobe cycle has not yet ended
   logic             inflight;     // a read strobe ended last edge; data_i holds its word
   logic [NUM-1:0]   rd_q;
   logic [NUM-1:0]   rd_nxt;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   logic             rd_active;
   logic             push;
   logic             pop;
   logic [CW-1:0]    count_nxt;
   logic             credit_ok;
   logic [CNT_W-1:0] len_sat;
   logic [CNT_W-1:0] to_load;
   logic             load_first;
   logic             load_next;

   assign rd_active = |rd_q;
   assign push      = inflight;
   assign pop       = (count != '0) && ready_i;
   assign count_nxt = count + CW'(push) - CW'(pop);

   // rd_o is registered, so the credit decision is made on next-cycle occupancy:
   // the FIFO after this edge, plus the strobe now ending (in flight next cycle),
   // plus the strobe about to be loaded must fit in FIFO_DEPTH.
   assign credit_ok = ({1'b0, count_nxt} + (CW+1)'(rd_active)) < (CW+1)'(FIFO_DEPTH);

   assign len_sat    = (len_i > CNT_W'(NUM)) ? CNT_W'(NUM) : len_i;
   assign to_load    = remain - CNT_W'(rd_active);
   assign load_first = (state == IDLE) && start_i && (len_i != '0);
   assign load_next  = (state == ISSUE) && (to_load != '0) && credit_ok;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_i) state_nxt = (len_i == '0) ? DONE : ISSUE;
         // Leave on the edge that ends the final strobe cycle.
         ISSUE: if (rd_active && (remain == CNT_W'(1))) state_nxt = DRAIN;
         DRAIN: if (!inflight && (count == '0)) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_o = (state != IDLE);
      done_o = (state == DONE);
   end

   // ---------------- strobe generation ----------------
   always_comb begin
      rd_nxt = '0;
      if (load_first)     rd_nxt[first_i] = 1'b1;
      else if (load_next) rd_nxt[ptr]     = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q     <= '0;
         ptr      <= '0;
         remain   <= '0;
         inflight <= 1'b0;
      end else begin
         rd_q     <= rd_nxt;
         // A strobe this cycle means its word arrives next cycle; otherwise the
         // previous word is pushed now and nothing is left outstanding.
         inflight <= rd_active;
         if (load_first)     ptr <= first_i + IDX_W'(1);
         else if (load_next) ptr <= ptr + IDX_W'(1);   // NUM is 2**IDX_W: wraps naturally
         if (load_first)                         remain <= len_sat;
         else if ((state == ISSUE) && rd_active) remain <= remain - CNT_W'(1);
      end
   end

   assign rd_o = rd_q;

   // ---------------- output FIFO ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         count <= count_nxt;
      end
   end

   assign valid_o = (count != '0);
   assign data_o  = mem[rd_ptr];

endmodule

// File: tb/tb_bin_bank_read_seq.sv
module tb_bin_bank_read_seq;
   localparam int NUM = 8, WIDTH = 5, IDX_W = 3, CNT_W = 4, FIFO_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic [IDX_W-1:0] first_i;
   logic [CNT_W-1:0] len_i;
   logic [NUM-1:0]   rd_o;
   logic [WIDTH-1:0] data_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;
   logic             busy_o;
   logic             done_o;

   bin_bank_read_seq #(.NUM(NUM), .WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W),
                       .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .first_i(first_i), .len_i(len_i),
      .rd_o(rd_o), .data_i(data_i), .data_o(data_o), .valid_o(valid_o),
      .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   logic [NUM-1:0]   exp_rd[$];
   logic [WIDTH-1:0] exp_data[$];
   logic [NUM-1:0]   rd_seen = '0;

   // Distinct word stored in each bank: 7,10,13,...,28.
   function automatic logic [WIDTH-1:0] word(int k);
      return WIDTH'(3 * k + 7);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bank + reducer model: the word selected by a strobe appears on data_i for
   // the whole following cycle.
   always @(negedge clk) rd_seen = rd_o;
   always @(posedge clk) begin
      logic [WIDTH-1:0] w;
      #1;
      w = '0;
      for (int k = 0; k < NUM; k++) if (rd_seen[k]) w = w | word(k);
      data_i = w;
   end

   // Monitor: strobes and accepted words are popped from the scoreboard in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_o != '0) begin
            rd_cnt++;
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rd_o), 0);
            else                    chk("rd_seq", 32'(rd_o), 32'(exp_rd.pop_front()));
         end
         if (valid_o && ready_i) begin
            if (exp_data.size() == 0) chk("data_unexpected", 32'(valid_o), 0);
            else                      chk("data_seq", 32'(data_o), 32'(exp_data.pop_front()));
         end
         if (done_o) done_cnt++;
      end
   end

   // Drive a one-cycle start; the DUT samples it at the next rising edge (E0).
   // Returns just after E0. Expectations are queued only when `expect_it` is set.
   task automatic start_seq(int first, int len, bit expect_it);
      int n;
      @(posedge clk); #1;
      start_i = 1'b1;
      first_i = IDX_W'(first);
      len_i   = CNT_W'(len);
      if (expect_it) begin
         n = (len > NUM) ? NUM : len;
         for (int i = 0; i < n; i++) begin
            exp_rd.push_back(NUM'(1) << ((first + i) % NUM));
            exp_data.push_back(word((first + i) % NUM));
         end
      end
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(string name);
      int n;
      n = 0;
      @(negedge clk);
      while (done_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_seen"}, 32'(done_o), 1);
      @(negedge clk);
      chk({name, "_done_single"}, 32'(done_o), 0);
      chk({name, "_busy_drop"}, 32'(busy_o), 0);
   endtask

   initial begin
      int base;
      rst = 1'b1; start_i = 1'b0; first_i = '0; len_i = '0; ready_i = 1'b1; data_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_rd", 32'(rd_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_data", 32'(data_o), 0);
      rst = 1'b0;

      // 1: first=2 len=4; strobe in C1, valid_o from C3
      start_seq(2, 4, 1);
      @(negedge clk);
      chk("t1_first_rd", 32'(rd_o), 32'h04);
      chk("t1_busy", 32'(busy_o), 1);
      @(negedge clk);
      chk("t1_valid_c2", 32'(valid_o), 0);
      @(negedge clk);
      chk("t1_valid_c3", 32'(valid_o), 1);
      wait_done("t1");

      // 2: wrap 6,7,0,1
      start_seq(6, 4, 1);
      wait_done("t2");

      // 3: backpressure, FIFO fills after exactly 4 strobes
      ready_i = 1'b0;
      base = rd_cnt;
      start_seq(0, 8, 1);
      repeat (10) @(negedge clk);
      chk("t3_strobes_stalled", 32'(rd_cnt - base), 4);
      chk("t3_rd_idle", 32'(rd_o), 0);
      chk("t3_valid", 32'(valid_o), 1);
      chk("t3_head", 32'(data_o), 32'(word(0)));
      ready_i = 1'b1;
      wait_done("t3");
      chk("t3_strobes_total", 32'(rd_cnt - base), 8);

      // 4a: len=0 -> DONE in the cycle after the start cycle, no strobes
      base = rd_cnt;
      start_seq(5, 0, 1);
      @(negedge clk);
      chk("t4a_done", 32'(done_o), 1);
      chk("t4a_rd", 32'(rd_o), 0);
      @(negedge clk);
      chk("t4a_done_single", 32'(done_o), 0);
      chk("t4a_idle", 32'(busy_o), 0);
      chk("t4a_no_strobes", 32'(rd_cnt - base), 0);

      // 4b: len=12 saturates to 8
      base = rd_cnt;
      start_seq(3, 12, 1);
      wait_done("t4b");
      chk("t4b_strobes", 32'(rd_cnt - base), 8);

      // 5: start during ISSUE is ignored
      start_seq(1, 5, 1);
      start_seq(5, 2, 0);
      wait_done("t5");

      // 6: reset mid-ISSUE with a read in flight and a word queued
      start_seq(4, 6, 1);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("t6_pre_valid", 32'(valid_o), 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_rd", 32'(rd_o), 0);
      chk("t6_rst_valid", 32'(valid_o), 0);
      chk("t6_rst_busy", 32'(busy_o), 0);
      exp_rd.delete();
      exp_data.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_seq(0, 2, 1);
      wait_done("t6");

      repeat (3) @(negedge clk);
      chk("rd_queue_empty", 32'(exp_rd.size()), 0);
      chk("data_queue_empty", 32'(exp_data.size()), 0);
      chk("done_pulses", 32'(done_cnt), 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
